softmax_vmax_reduce: RTL and testbench
======================================

# softmax_vmax_reduce

Row-maximum stage of the softmax datapath, directly downstream of the vector load stage that fills the 32 x 1024-bit vector registers. It accepts one 1024-bit vector register value (32 fp32 lanes) over a valid/ready handshake. It scans the active lanes LPC per cycle and returns the numerically largest fp32 value, its lane index, and a NaN flag. The subtract-max / exp stage consumes the result.

## Interface
- VLEN, 1024, vector register width in bits
- ELEN, 32, lane width (fp32); NLANES = VLEN/ELEN = 32
- LPC, 4, lanes compared per scan cycle; must divide NLANES
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  vector offered
- in_ready  output  1  block can accept a vector
- in_data  input  VLEN  lane i = in_data[i*32 +: 32]
- in_vl  input  6  active lane count, 0..32; values >32 are clamped to 32
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- out_max  output  32  maximum fp32 bit pattern
- out_idx  output  5  lane index of out_max
- out_nan  output  1  at least one active lane was NaN

## Operation
- FSM states: IDLE, SCAN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE).
- IDLE: on in_valid && in_ready, capture in_data into a VLEN-bit buffer and clamped vl into vl_q. Set ptr=0, acc_key=0, acc_idx=0, nan_q=0.
  - vl_q==0: go to DONE.
  - otherwise: go to SCAN.
- SCAN: each cycle examines lanes ptr..ptr+LPC-1, ignoring lanes >= vl_q, and ptr += LPC. When ptr+LPC >= vl_q, go to DONE.
- Ordering key: key = sign ? ~bits : (bits | 0x8000_0000), compared as unsigned 32-bit. A larger key wins.
  - +0 beats -0.
  - -inf is the least value, +inf the greatest.
- Ties (equal key): the lower lane index wins, both within a group and against the accumulator.
- NaN (exp==0xFF, mant!=0): the first NaN lane in index order sets nan_q=1 and latches acc_idx to that lane. Later lanes never change the result once nan_q=1.
- Result values:
  - NaN seen: out_max = 0x7FC0_0000 (canonical qNaN), out_nan = 1.
  - vl_q==0: out_max = 0xFF80_0000 (-inf), out_idx = 0, out_nan = 0.
  - otherwise: out_max = bits of the winning lane.
- DONE: hold out_max, out_idx and out_nan stable while out_valid=1. On out_ready, return to IDLE.
- No overlap: in_ready=0 in SCAN and DONE. in_data changes after the accept edge have no effect.

## Timing
- Accept edge T, where in_valid && in_ready are sampled high.
- out_valid goes high in the cycle after edge T + ceil(vl_q/LPC).
  - vl=32, LPC=4: 8 edges.
  - vl=1: 1 edge.
  - vl=0: high in the cycle right after T.
- out_valid deasserts in the cycle after the edge where out_ready is sampled high; in_ready reasserts in that same cycle.
- Minimum spacing between accepts: ceil(vl/LPC)+2 edges when out_ready is held high.
- Reset values, applied at a reset edge in any state: state=IDLE, so in_ready=1; out_valid=0, out_max=0, out_idx=0, out_nan=0.
  - Reset during SCAN or DONE discards the vector in flight; no result is emitted.
- reset has priority over in_valid and out_ready sampled on the same edge.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.

## Test plan
- Lanes i=0..31 = float(i) (lane 31 = 0x41F8_0000), vl=32 -> out_max=0x41F8_0000, idx=31, nan=0; out_valid exactly 8 cycles after accept.
- All lanes -1.0 (0xBF80_0000) except lane 5 = -0.0 and lane 9 = +0.0, vl=32 -> out_max=0x0000_0000, idx=9.
- Lanes 3 and 17 = 2.0, rest 1.0, vl=20 -> idx=3. Same vector with vl=3 -> out_max=0x3F80_0000 (1.0), idx=0, out_valid after 1 cycle.
- Lane 6 = 0x7F80_0001 (NaN), lane 10 = +inf, rest 0 -> out_max=0x7FC0_0000, idx=6, nan=1. Same vector with vl=6 -> out_max=0x7F80_0000? No: lane 10 is inactive, so the result is 0x0000_0000, idx=0, nan=0.
- vl=0 -> out_max=0xFF80_0000, idx=0, nan=0, out_valid the cycle after accept. in_vl=40 with lane 31 the largest -> idx=31, 8 scan cycles.
- Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0. Assert reset at scan cycle 3 -> out_valid never rises; the next accept gives the correct result.

Source files
------------

// File: rtl/softmax_vmax_reduce.sv
// softmax_vmax_reduce: scans one 32-lane fp32 vector LPC lanes per cycle and
// returns the largest value, its lane index and a NaN flag.
module softmax_vmax_reduce #(
   parameter int unsigned VLEN = 1024,
   parameter int unsigned ELEN = 32,
   parameter int unsigned LPC  = 4
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [VLEN-1:0] in_data,
   input  logic [5:0]      in_vl,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_max,
   output logic [4:0]      out_idx,
   output logic            out_nan
);

   localparam int unsigned NLANES = VLEN / ELEN;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t          state_q, state_d;
   logic [VLEN-1:0] buf_q, buf_d;
   logic [5:0]      vl_q, vl_d;
   logic [5:0]      ptr_q, ptr_d;
   logic [31:0]     acc_key_q, acc_key_d;
   logic [4:0]      acc_idx_q, acc_idx_d;
   logic            nan_q, nan_d;
   logic            in_ready_d, out_valid_d, out_nan_d;
   logic [31:0]     out_max_d;
   logic [4:0]      out_idx_d;
   logic [5:0]      scan_lane;
   logic [31:0]     scan_bits;

   // Monotonic ordering key: unsigned compare of keys matches fp32 order.
   function automatic logic [31:0] fp_key(input logic [31:0] b);
      return b[31] ? ~b : (b | 32'h8000_0000);
   endfunction

   // Inverse of fp_key, recovers the lane bit pattern from the accumulator.
   function automatic logic [31:0] key_bits(input logic [31:0] k);
      return k[31] ? {1'b0, k[30:0]} : ~k;
   endfunction

   function automatic logic is_nan(input logic [31:0] b);
      return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
   endfunction

   // Next-state, scan datapath and result formation.
   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      vl_d      = vl_q;
      ptr_d     = ptr_q;
      acc_key_d = acc_key_q;
      acc_idx_d = acc_idx_q;
      nan_d     = nan_q;
      out_max_d = out_max;
      out_idx_d = out_idx;
      out_nan_d = out_nan;
      scan_lane = 6'd0;
      scan_bits = 32'd0;

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               buf_d     = in_data;
               vl_d      = (in_vl > 6'(NLANES)) ? 6'(NLANES) : in_vl;
               ptr_d     = 6'd0;
               acc_key_d = 32'd0;
               acc_idx_d = 5'd0;
               nan_d     = 1'b0;
               if (vl_d == 6'd0) begin
                  state_d   = DONE;
                  out_max_d = 32'hFF80_0000;
                  out_idx_d = 5'd0;
                  out_nan_d = 1'b0;
               end else begin
                  state_d = SCAN;
               end
            end
         end
         SCAN: begin
            // Lanes visited in index order with strict compare: lower index wins ties.
            for (int unsigned j = 0; j < LPC; j++) begin
               scan_lane = ptr_q + 6'(j);
               scan_bits = buf_q[32'(5'(scan_lane)) * ELEN +: 32];
               if ((scan_lane < vl_q) && !nan_d) begin
                  if (is_nan(scan_bits)) begin
                     nan_d     = 1'b1;
                     acc_idx_d = 5'(scan_lane);
                  end else if (fp_key(scan_bits) > acc_key_d) begin
                     acc_key_d = fp_key(scan_bits);
                     acc_idx_d = 5'(scan_lane);
                  end
               end
            end
            ptr_d = ptr_q + 6'(LPC);
            if ((7'(ptr_q) + 7'(LPC)) >= 7'(vl_q)) begin
               state_d   = DONE;
               out_max_d = nan_d ? 32'h7FC0_0000 : key_bits(acc_key_d);
               out_idx_d = acc_idx_d;
               out_nan_d = nan_d;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State and datapath registers, synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         buf_q     <= '0;
         vl_q      <= 6'd0;
         ptr_q     <= 6'd0;
         acc_key_q <= 32'd0;
         acc_idx_q <= 5'd0;
         nan_q     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_max   <= 32'd0;
         out_idx   <= 5'd0;
         out_nan   <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         vl_q      <= vl_d;
         ptr_q     <= ptr_d;
         acc_key_q <= acc_key_d;
         acc_idx_q <= acc_idx_d;
         nan_q     <= nan_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
         out_max   <= out_max_d;
         out_idx   <= out_idx_d;
         out_nan   <= out_nan_d;
      end
   end

endmodule

// File: tb/tb_softmax_vmax_reduce.sv
// Testbench for softmax_vmax_reduce: directed and random vectors against a
// sign/magnitude reference model of fp32 maximum.
module tb_softmax_vmax_reduce;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [1023:0] in_data;
   logic [5:0]    in_vl;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_max;
   logic [4:0]    out_idx;
   logic          out_nan;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] lanes [32];
   logic [31:0] exp_max;
   logic [4:0]  exp_idx;
   logic        exp_nan;

   softmax_vmax_reduce dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_vl(in_vl),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_max(out_max), .out_idx(out_idx), .out_nan(out_nan)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic fnan(input logic [31:0] b);
      return (b[30:23] == 8'hFF) && (b[22:0] != 0);
   endfunction

   // a strictly greater than b (non-NaN); +0 counts as greater than -0.
   function automatic logic fgt(input logic [31:0] a, input logic [31:0] b);
      if (a[31] != b[31]) return b[31];
      if (!a[31]) return a[30:0] > b[30:0];
      return a[30:0] < b[30:0];
   endfunction

   function automatic logic [31:0] int_to_fp(input int v);
      int p;
      if (v == 0) return 32'd0;
      p = 0;
      for (int k = 0; k < 31; k++) if ((v >> k) != 0) p = k;
      return {1'b0, 8'(127 + p), 23'((v << (23 - p)) & 32'h7F_FFFF)};
   endfunction

   // Reference: linear scan over active lanes.
   task automatic model(input int vlc);
      logic have;
      exp_max = 32'hFF80_0000; exp_idx = 0; exp_nan = 0; have = 0;
      for (int i = 0; i < vlc; i++) begin
         if (fnan(lanes[i])) begin
            exp_max = 32'h7FC0_0000; exp_idx = 5'(i); exp_nan = 1;
            break;
         end
         if (!have || fgt(lanes[i], exp_max)) begin
            exp_max = lanes[i]; exp_idx = 5'(i); have = 1;
         end
      end
   endtask

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic run_vec(input string tag, input int vl, input int hold);
      int vlc, lat, guard;
      vlc = (vl > 32) ? 32 : vl;
      model(vlc);
      guard = 0;
      while (!in_ready && guard < 50) begin step(); guard++; end
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      for (int i = 0; i < 32; i++) in_data[i*32 +: 32] = lanes[i];
      in_vl = 6'(vl);
      in_valid = 1;
      step();
      in_valid = 0;
      in_data = {32{$urandom()}};
      in_vl = 6'($urandom_range(0, 63));
      lat = 0;
      while (!out_valid && lat < 50) begin step(); lat++; end
      check({tag, "_latency"}, 32'(lat), 32'((vlc + 3) / 4));
      check({tag, "_max"}, out_max, exp_max);
      check({tag, "_idx"}, 32'(out_idx), 32'(exp_idx));
      check({tag, "_nan"}, 32'(out_nan), 32'(exp_nan));
      for (int k = 0; k < hold; k++) begin
         step();
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
         check({tag, "_hold_max"}, out_max, exp_max);
         check({tag, "_hold_idx"}, 32'(out_idx), 32'(exp_idx));
      end
      out_ready = 1;
      step();
      out_ready = 0;
      check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_release_ready"}, 32'(in_ready), 32'd1);
   endtask

   function automatic logic [31:0] rand_lane();
      case ($urandom_range(0, 11))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'h7F80_0000;
         3: return 32'hFF80_0000;
         4: return ($urandom_range(0, 7) == 0) ? {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))} : 32'h3F80_0000;
         5: return 32'h3F80_0000;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      reset = 1; in_valid = 0; in_data = '0; in_vl = 0; out_ready = 0;
      step(); step();
      reset = 0;
      check("reset_in_ready", 32'(in_ready), 32'd1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_out_max", out_max, 32'd0);
      check("reset_out_idx", 32'(out_idx), 32'd0);
      check("reset_out_nan", 32'(out_nan), 32'd0);

      for (int i = 0; i < 32; i++) lanes[i] = int_to_fp(i);
      check("fp31_const", lanes[31], 32'h41F8_0000);
      run_vec("ramp32", 32, 0);
      check("ramp32_abs", out_max, 32'h41F8_0000);

      for (int i = 0; i < 32; i++) lanes[i] = 32'hBF80_0000;
      lanes[5] = 32'h8000_0000; lanes[9] = 32'h0000_0000;
      run_vec("zeros", 32, 0);

      for (int i = 0; i < 32; i++) lanes[i] = 32'h3F80_0000;
      lanes[3] = 32'h4000_0000; lanes[17] = 32'h4000_0000;
      run_vec("tie20", 20, 0);
      run_vec("tie3", 3, 0);

      for (int i = 0; i < 32; i++) lanes[i] = 32'h0;
      lanes[6] = 32'h7F80_0001; lanes[10] = 32'h7F80_0000;
      run_vec("nan32", 32, 0);
      run_vec("nan6", 6, 0);
      run_vec("vl0", 0, 0);

      for (int i = 0; i < 32; i++) lanes[i] = int_to_fp(i);
      run_vec("vl40", 40, 0);
      for (int i = 0; i < 32; i++) lanes[i] = $urandom();
      run_vec("hold5", 32, 5);

      // Reset in the middle of a scan discards the vector.
      for (int i = 0; i < 32; i++) in_data[i*32 +: 32] = int_to_fp(i);
      in_vl = 32; in_valid = 1;
      step();
      in_valid = 0;
      step(); step();
      reset = 1;
      step();
      reset = 0;
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_max", out_max, 32'd0);
      for (int k = 0; k < 12; k++) begin
         check("midrst_no_valid", 32'(out_valid), 32'd0);
         step();
      end
      for (int i = 0; i < 32; i++) lanes[i] = 32'hC000_0000 - 32'(i);
      run_vec("after_rst", 32, 1);

      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < 32; i++) lanes[i] = rand_lane();
         if ($urandom_range(0, 3) == 0) lanes[$urandom_range(0, 31)] = lanes[$urandom_range(0, 31)];
         run_vec("rand", int'($urandom_range(0, 40)), int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
